// File: rtl/z8s180_boot_glue.sv
// Z8S180 board glue: EXTAL divider, stretched CPU reset, boot ROM decode with
// wait-state insertion, and an I/O-port latch that pages the boot ROM out.
module z8s180_boot_glue #(
    parameter int         CLK_DIV     = 2,
    parameter int         RESET_HOLD  = 1024,
    parameter int         ROM_AW      = 9,
    parameter int         WAIT_STATES = 0,
    parameter logic [7:0] ROMDIS_PORT = 8'hFE
) (
    input  logic              hwclk,
    input  logic              s1_n,
    input  logic [19:0]       a,
    input  logic [7:0]        d_in,
    input  logic              mreq_n,
    input  logic              iorq_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              m1_n,
    input  logic              phi,
    input  logic [7:0]        rom_data,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [7:0]        d_out,
    output logic              d_oe,
    output logic              extal,
    output logic              reset_n,
    output logic              wait_n,
    output logic              rom_en
);

    localparam int  DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int  HW      = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam int  CW      = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam bit  WAIT_EN = (WAIT_STATES > 0);

    // ------------------------------------------------------------------
    // EXTAL divider: toggles at mid-count and at wrap for a 50% duty cycle
    // ------------------------------------------------------------------
    logic [DW-1:0] div_cnt;

    always_ff @(posedge hwclk or negedge s1_n) begin
        if (!s1_n) begin
            div_cnt <= '0;
            extal   <= 1'b0;
        end else begin
            if (div_cnt == DW'(CLK_DIV - 1))
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 1'b1;
            if (div_cnt == DW'(CLK_DIV / 2 - 1) || div_cnt == DW'(CLK_DIV - 1))
                extal <= ~extal;
        end
    end

    // ------------------------------------------------------------------
    // CPU reset stretch
    // ------------------------------------------------------------------
    typedef enum logic {R_HOLD, R_RUN} rst_state_t;

    rst_state_t    rst_state;
    logic [1:0]    s1_sync;
    logic [HW-1:0] hold_cnt;

    always_ff @(posedge hwclk or negedge s1_n) begin
        if (!s1_n) begin
            s1_sync   <= 2'b00;
            hold_cnt  <= '0;
            rst_state <= R_HOLD;
            reset_n   <= 1'b0;
        end else begin
            s1_sync <= {s1_sync[0], 1'b1};
            case (rst_state)
                R_HOLD: begin
                    if (s1_sync[1]) begin
                        if (hold_cnt == HW'(RESET_HOLD - 1)) begin
                            rst_state <= R_RUN;
                            reset_n   <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                R_RUN: reset_n <= 1'b1;
                default: begin
                    rst_state <= R_HOLD;
                    reset_n   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Boot ROM decode; purely combinational so data meets the CPU read window
    // ------------------------------------------------------------------
    logic rom_sel;

    assign rom_sel  = rom_en & reset_n & ~mreq_n & ~rd_n & (a[19:ROM_AW] == '0);
    assign d_oe     = rom_sel;
    assign d_out    = rom_data;
    assign rom_addr = a[ROM_AW-1:0];

    // ------------------------------------------------------------------
    // Wait-state FSM, counting synchronised PHI rising edges
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_DONE} wait_state_t;

    wait_state_t   wait_state;
    logic [CW-1:0] wait_cnt;
    logic [2:0]    phi_sync;
    logic          phi_rise;

    assign phi_rise = phi_sync[1] & ~phi_sync[2];

    always_ff @(posedge hwclk or negedge s1_n) begin
        if (!s1_n) begin
            phi_sync   <= 3'b000;
            wait_state <= W_IDLE;
            wait_cnt   <= '0;
        end else begin
            phi_sync <= {phi_sync[1:0], phi};
            if (!rom_sel) begin
                wait_state <= W_IDLE;
                wait_cnt   <= '0;
            end else begin
                case (wait_state)
                    W_IDLE: begin
                        if (WAIT_EN) begin
                            wait_state <= W_WAIT;
                            wait_cnt   <= '0;
                        end
                    end
                    W_WAIT: begin
                        if (phi_rise) begin
                            wait_cnt <= wait_cnt + 1'b1;
                            if (wait_cnt == CW'(WAIT_STATES - 1))
                                wait_state <= W_DONE;
                        end
                    end
                    W_DONE: wait_state <= W_DONE;
                    default: wait_state <= W_IDLE;
                endcase
            end
        end
    end

    // Low in the very cycle the read starts; the FSM only releases it.
    assign wait_n = ~(rom_sel & (wait_state != W_DONE) & WAIT_EN);

    // ------------------------------------------------------------------
    // ROM-disable port; interrupt-acknowledge cycles (m1_n=0) never match
    // ------------------------------------------------------------------
    logic       io_wr;
    logic [2:0] io_sync;
    logic       io_rise;
    logic       d_unused;

    assign io_wr    = ~iorq_n & ~wr_n & m1_n & (a[7:0] == ROMDIS_PORT);
    assign io_rise  = io_sync[1] & ~io_sync[2];
    assign d_unused = ^d_in[7:1];

    always_ff @(posedge hwclk or negedge s1_n) begin
        if (!s1_n) begin
            io_sync <= 3'b000;
            rom_en  <= 1'b1;
        end else begin
            io_sync <= {io_sync[1:0], io_wr};
            if (io_rise && d_in[0])
                rom_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_z8s180_boot_glue.sv
// Randomised bench for z8s180_boot_glue against a cycle-history reference model.
module tb_z8s180_boot_glue;

    localparam int CLK_DIV    = 4;
    localparam int RESET_HOLD = 8;
    localparam int ROM_AW     = 9;
    localparam int WS         = 2;

    logic        hwclk = 1'b0;
    logic        s1_n;
    logic [19:0] a;
    logic [7:0]  d_in, rom_data;
    logic        mreq_n, iorq_n, rd_n, wr_n, m1_n;
    logic        phi = 1'b0;

    logic [8:0]  rom_addr, rom_addr0;
    logic [7:0]  d_out, d_out0;
    logic        d_oe, d_oe0, extal, extal0, reset_n, reset_n0;
    logic        wait_n, wait_n0, rom_en, rom_en0;

    int total = 0;
    int bad   = 0;

    z8s180_boot_glue #(.CLK_DIV(CLK_DIV), .RESET_HOLD(RESET_HOLD), .ROM_AW(ROM_AW),
                       .WAIT_STATES(WS), .ROMDIS_PORT(8'hFE)) u_dut (
        .hwclk(hwclk), .s1_n(s1_n), .a(a), .d_in(d_in), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .phi(phi), .rom_data(rom_data),
        .rom_addr(rom_addr), .d_out(d_out), .d_oe(d_oe), .extal(extal), .reset_n(reset_n),
        .wait_n(wait_n), .rom_en(rom_en));

    z8s180_boot_glue #(.CLK_DIV(CLK_DIV), .RESET_HOLD(RESET_HOLD), .ROM_AW(ROM_AW),
                       .WAIT_STATES(0), .ROMDIS_PORT(8'hFE)) u_ws0 (
        .hwclk(hwclk), .s1_n(s1_n), .a(a), .d_in(d_in), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .phi(phi), .rom_data(rom_data),
        .rom_addr(rom_addr0), .d_out(d_out0), .d_oe(d_oe0), .extal(extal0), .reset_n(reset_n0),
        .wait_n(wait_n0), .rom_en(rom_en0));

    always #5 hwclk = ~hwclk;

    // PHI is unrelated to hwclk; it changes 3ns after a negedge, never on a posedge
    initial begin
        #3;
        forever begin
            #($urandom_range(2, 6) * 10);
            phi = ~phi;
        end
    end

    // ---------------- reference model ----------------
    int  n;           // hwclk edges since s1_n release
    bit  rom_en_m;
    bit  in_read;     // read already seen at a previous edge
    int  counted;     // PHI rises seen by the wait logic during this read
    bit  io_h  [0:4095];
    bit  phi_h [0:4095];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        n = 0; rom_en_m = 1'b1; in_read = 1'b0; counted = 0;
        foreach (io_h[i])  io_h[i]  = 1'b0;
        foreach (phi_h[i]) phi_h[i] = 1'b0;
    endtask

    function automatic bit exp_rst();
        return n >= 2 + RESET_HOLD;
    endfunction

    function automatic bit exp_sel();
        return rom_en_m && exp_rst() && !mreq_n && !rd_n && (a[19:ROM_AW] == '0);
    endfunction

    task automatic check_outputs();
        bit ext_e, sel_e, wait_e;
        ext_e  = (n % CLK_DIV) >= CLK_DIV / 2;
        sel_e  = exp_sel();
        wait_e = !(sel_e && (!in_read || counted < WS));
        chk("extal",    32'(extal),    32'(ext_e));
        chk("extal0",   32'(extal0),   32'(ext_e));
        chk("reset_n",  32'(reset_n),  32'(exp_rst()));
        chk("rom_en",   32'(rom_en),   32'(rom_en_m));
        chk("rom_en0",  32'(rom_en0),  32'(rom_en_m));
        chk("d_oe",     32'(d_oe),     32'(sel_e));
        chk("d_oe0",    32'(d_oe0),    32'(sel_e));
        chk("d_out",    32'(d_out),    32'(rom_data));
        chk("rom_addr", 32'(rom_addr), 32'(a[8:0]));
        chk("wait_n",   32'(wait_n),   32'(wait_e));
        chk("wait_n0",  32'(wait_n0),  32'd1);
    endtask

    task automatic model_edge();
        bit sel, io;
        if (!s1_n) return;
        sel = exp_sel();
        io  = !iorq_n && !wr_n && m1_n && (a[7:0] == 8'hFE);
        n++;
        io_h[12'(n)]  = io;
        phi_h[12'(n)] = phi;
        if (sel) begin
            if (!in_read) begin
                in_read = 1'b1;
                counted = 0;
            end else if (n >= 3 && phi_h[12'(n - 2)] && !phi_h[12'(n - 3)]) begin
                counted++;
            end
        end else begin
            in_read = 1'b0;
        end
        // a port write seen at edge j takes effect two edges later, with d_in at that edge
        if (n >= 3 && io_h[12'(n - 2)] && !io_h[12'(n - 3)] && d_in[0])
            rom_en_m = 1'b0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            #1 check_outputs();
            @(posedge hwclk);
            model_edge();
            @(negedge hwclk);
        end
    endtask

    task automatic bus_idle();
        a = 20'($urandom); d_in = 8'($urandom); rom_data = 8'($urandom);
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    endtask

    task automatic rom_read(input logic [19:0] addr, input logic [7:0] data);
        bus_idle();
        a = addr; rom_data = data; mreq_n = 1'b0; rd_n = 1'b0;
    endtask

    task automatic io_write(input logic [7:0] port, input logic [7:0] data, input logic m1);
        bus_idle();
        a = {12'h000, port}; d_in = data; iorq_n = 1'b0; wr_n = 1'b0; m1_n = m1;
    endtask

    task automatic hold_reset(input int cycles);
        s1_n = 1'b0;
        model_reset();
        step(cycles);
        s1_n = 1'b1;
    endtask

    // s1_n drops in the low half of hwclk, away from any edge
    task automatic async_reset();
        #2 s1_n = 1'b0;
        model_reset();
        #1 check_outputs();
        @(posedge hwclk);
        model_edge();
        @(negedge hwclk);
    endtask

    task automatic random_txn();
        int kind, len;
        kind = $urandom_range(0, 9);
        len  = $urandom_range(1, 20);
        case (kind)
            0, 1, 2, 3, 4: rom_read(20'($urandom_range(0, 511)), 8'($urandom));
            5: rom_read({11'($urandom_range(1, 2047)), 9'($urandom)}, 8'($urandom));
            6: bus_idle();
            7: io_write(8'hFE, {7'($urandom), ($urandom_range(0, 3) == 0)}, 1'b1);
            8: io_write(($urandom_range(0, 1) == 1) ? 8'hFD : 8'hFE, 8'hFF,
                        ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0);
            default: begin
                rom_read(20'($urandom_range(0, 511)), 8'($urandom));
                rd_n = 1'b1;
            end
        endcase
        if (kind == 8 && a[7:0] == 8'hFE) m1_n = 1'b0;
        step(len);
        if ($urandom_range(0, 1) == 1) begin
            bus_idle();
            step(1);
        end
    endtask

    initial begin
        s1_n = 1'b0;
        bus_idle();
        model_reset();
        @(negedge hwclk);

        // reset state, divider phase and exact stretch length
        hold_reset(3);
        step(14);

        // s1_n pulse in the middle of the stretch restarts it
        hold_reset(1);
        step(5);
        async_reset();
        step(2);
        s1_n = 1'b1;
        step(14);

        // ROM decode and wait states
        rom_read(20'h00123, 8'hC3);
        step(30);
        bus_idle();
        step(1);
        rom_read(20'h00200, 8'h55);
        step(3);
        rom_read(20'h00123, 8'hC3);
        rd_n = 1'b1;
        step(2);
        rom_read(20'h00010, 8'h3E);
        step(25);
        bus_idle();
        step(1);
        rom_read(20'h00011, 8'h21);
        step(25);
        bus_idle();
        step(1);

        // writes that must not page the ROM out, then one that does
        io_write(8'hFD, 8'h01, 1'b1); step(4); bus_idle(); step(1);
        io_write(8'hFE, 8'h01, 1'b0); step(4); bus_idle(); step(1);
        io_write(8'hFE, 8'h00, 1'b1); step(4); bus_idle(); step(1);
        rom_read(20'h00005, 8'hAA);   step(3); bus_idle(); step(1);
        io_write(8'hFE, 8'h01, 1'b1); step(4); bus_idle(); step(1);
        rom_read(20'h00005, 8'hAA);   step(3); bus_idle(); step(1);

        // s1_n during a ROM wait
        hold_reset(2);
        step(12);
        rom_read(20'h00042, 8'h99);
        step(3);
        async_reset();
        step(2);
        s1_n = 1'b1;
        bus_idle();
        step(12);

        for (int seg = 0; seg < 25; seg++) begin
            bus_idle();
            hold_reset($urandom_range(1, 3));
            step(12);
            for (int t = 0; t < 10; t++)
                random_txn();
            if ($urandom_range(0, 1) == 1) begin
                rom_read(20'($urandom_range(0, 511)), 8'($urandom));
                step($urandom_range(1, 3));
                async_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
